// File: rtl/mac_acc_bank.sv
// rtl/mac_acc_bank.sv - multi-channel signed multiply-accumulate bank with a held result register
// Optional build macro: MAC_ACC_SAT_EN (saturating adds instead of wrapping adds).
module mac_acc_bank #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 22,
  parameter int NCH    = 4,
  parameter int CH_W   = $clog2(NCH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH_W-1:0]          in_ch,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_ch,
  output logic signed [ACC_W-1:0]  out_data,
  output logic                     out_ovf
);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W-1:0] acc [NCH];
  logic [NCH-1:0]          ovf;

  logic signed [ACC_W-1:0] sel_acc;
  logic signed [ACC_W-1:0] ext;
  logic signed [ACC_W-1:0] raw_sum;
  logic signed [ACC_W-1:0] sum;
  logic                    sel_ovf;
  logic                    hit;
  logic                    add_ovf;
  logic                    take;

  assign in_ready = !out_valid || out_ready;

  // Channel indices with no matching accumulator never hit, so such beats are dropped.
  always_comb begin
    sel_acc = '0;
    sel_ovf = 1'b0;
    hit     = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (in_ch == CH_W'(i)) begin
        sel_acc = acc[i];
        sel_ovf = ovf[i];
        hit     = 1'b1;
      end
    end
  end

  assign ext     = ACC_W'(in_data);
  assign raw_sum = sel_acc + ext;
  assign add_ovf = (sel_acc[ACC_W-1] == ext[ACC_W-1]) && (raw_sum[ACC_W-1] != sel_acc[ACC_W-1]);

`ifdef MAC_ACC_SAT_EN
  assign sum = add_ovf ? (sel_acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : raw_sum;
`else
  assign sum = raw_sum;
`endif

  assign take = in_valid && in_ready && hit && !clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) acc[i] <= '0;
      ovf <= '0;
    end else if (clr) begin
      for (int i = 0; i < NCH; i++) acc[i] <= '0;
      ovf <= '0;
    end else if (take) begin
      for (int i = 0; i < NCH; i++) begin
        if (in_ch == CH_W'(i)) begin
          if (in_last) begin
            acc[i] <= '0;
            ovf[i] <= 1'b0;
          end else begin
            acc[i] <= sum;
            ovf[i] <= ovf[i] | add_ovf;
          end
        end
      end
    end
  end

  // A last beat may reload the register in the same cycle the old result is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (clr) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (take && in_last) begin
      out_valid <= 1'b1;
      out_ch    <= in_ch;
      out_data  <= sum;
      out_ovf   <= sel_ovf | add_ovf;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_acc_bank.sv
// tb/tb_mac_acc_bank.sv - directed vector bench for mac_acc_bank
// Built with CH_W=3 so out-of-range channel indices can be driven.
module tb_mac_acc_bank;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 22;
  localparam int NCH    = 4;
  localparam int CH_W   = 3;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     clr;
  logic                     in_valid;
  logic                     in_ready;
  logic [CH_W-1:0]          in_ch;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [CH_W-1:0]          out_ch;
  logic signed [ACC_W-1:0]  out_data;
  logic                     out_ovf;

  int n_cmp  = 0;
  int n_fail = 0;

  mac_acc_bank #(.DATA_W(DATA_W), .ACC_W(ACC_W), .NCH(NCH), .CH_W(CH_W)) dut (
    .clk(clk), .reset(reset), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
    .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            v;
    logic [CH_W-1:0] ch;
    int              data;
    logic            last;
    logic            ordy;
    logic            exp_rdy;
    logic            exp_ov;
    logic [CH_W-1:0] exp_ch;
    int              exp_data;
    logic            exp_ovf;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int ch, input int data, input logic last, input logic ordy);
    in_valid  = v;
    in_ch     = CH_W'(ch);
    in_data   = DATA_W'(data);
    in_last   = last;
    out_ready = ordy;
  endtask

  task automatic apply(input vec_t t, input int idx);
    string nm;
    @(negedge clk);
    drive(t.v, int'(t.ch), t.data, t.last, t.ordy);
    #1;
    nm = $sformatf("vec%0d.in_ready", idx);
    chk(nm, longint'(in_ready), longint'(t.exp_rdy));
    @(posedge clk);
    #1;
    nm = $sformatf("vec%0d.out_valid", idx);
    chk(nm, longint'(out_valid), longint'(t.exp_ov));
    if (t.exp_ov) begin
      chk($sformatf("vec%0d.out_ch", idx), longint'(out_ch), longint'(t.exp_ch));
      chk($sformatf("vec%0d.out_data", idx), longint'(out_data), longint'(t.exp_data));
      chk($sformatf("vec%0d.out_ovf", idx), longint'(out_ovf), longint'(t.exp_ovf));
    end
  endtask

  initial begin
    longint exp_sat;
    reset = 1'b1;
    clr   = 1'b0;
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    #12;
    chk("reset.out_valid", longint'(out_valid), 0);
    chk("reset.out_data", longint'(out_data), 0);
    chk("reset.out_ch", longint'(out_ch), 0);
    chk("reset.out_ovf", longint'(out_ovf), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset.in_ready", longint'(in_ready), 1);

    //           v  ch data last ordy rdy ov ch  data ovf
    vq.push_back('{1, 0, 100,  0, 1, 1, 0, 0,   0, 0});
    vq.push_back('{1, 0, -30,  0, 1, 1, 0, 0,   0, 0});
    vq.push_back('{1, 0,   5,  1, 1, 1, 1, 0,  75, 0});
    vq.push_back('{0, 0,   0,  0, 1, 1, 0, 0,   0, 0});
    vq.push_back('{1, 1,  10,  0, 1, 1, 0, 0,   0, 0});
    vq.push_back('{1, 2,  20,  0, 1, 1, 0, 0,   0, 0});
    vq.push_back('{1, 1,   7,  1, 1, 1, 1, 1,  17, 0});
    vq.push_back('{1, 2, -25,  1, 1, 1, 1, 2,  -5, 0});
    vq.push_back('{0, 0,   0,  0, 1, 1, 0, 0,   0, 0});
    vq.push_back('{1, 3,   9,  0, 1, 1, 0, 0,   0, 0});
    vq.push_back('{1, 5, 1000, 1, 1, 1, 0, 0,   0, 0});
    vq.push_back('{1, 5,   7,  0, 1, 1, 0, 0,   0, 0});
    vq.push_back('{1, 3,   1,  1, 1, 1, 1, 3,  10, 0});
    vq.push_back('{0, 0,   0,  0, 1, 1, 0, 0,   0, 0});
    vq.push_back('{1, 0,  40,  1, 0, 1, 1, 0,  40, 0});
    vq.push_back('{1, 1,   5,  1, 0, 0, 1, 0,  40, 0});
    vq.push_back('{1, 1,   5,  1, 0, 0, 1, 0,  40, 0});
    vq.push_back('{1, 1,   5,  1, 1, 1, 1, 1,   5, 0});
    vq.push_back('{0, 0,   0,  0, 1, 1, 0, 0,   0, 0});

    for (int i = 0; i < vq.size(); i++) begin
      apply(vq[i], i);
      if (i == 8) begin
        chk("acc1_zero", longint'(dut.acc[1]), 0);
        chk("acc2_zero", longint'(dut.acc[2]), 0);
      end
    end
    chk("acc0_after_oob", longint'(dut.acc[0]), 0);
    chk("acc3_after_oob", longint'(dut.acc[3]), 0);

    // 65 full-scale beats push ch3 past the positive limit on the final add.
    for (int i = 0; i < 65; i++) begin
      @(negedge clk);
      drive(1'b1, 3, 32767, (i == 64), 1'b1);
      @(posedge clk);
    end
    #1;
`ifdef MAC_ACC_SAT_EN
    exp_sat = 2097151;
`else
    exp_sat = -2064449;
`endif
    chk("sat.out_valid", longint'(out_valid), 1);
    chk("sat.out_ch", longint'(out_ch), 3);
    chk("sat.out_data", longint'(out_data), exp_sat);
    chk("sat.out_ovf", longint'(out_ovf), 1);

    apply('{0, 0, 0, 0, 1, 1, 0, 0, 0, 0}, 100);
    apply('{1, 0, 50, 0, 1, 1, 0, 0, 0, 0}, 101);
    clr = 1'b1;
    apply('{1, 0, 0, 1, 1, 1, 0, 0, 0, 0}, 102);
    clr = 1'b0;
    chk("clr.acc0", longint'(dut.acc[0]), 0);
    apply('{1, 0, 6, 1, 1, 1, 1, 0, 6, 0}, 103);

    apply('{1, 2, 3, 0, 1, 1, 0, 0, 0, 0}, 104);
    apply('{1, 1, 8, 1, 0, 1, 1, 1, 8, 0}, 105);
    @(negedge clk);
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst.out_valid", longint'(out_valid), 0);
    chk("async_rst.out_data", longint'(out_data), 0);
    chk("async_rst.out_ch", longint'(out_ch), 0);
    chk("async_rst.out_ovf", longint'(out_ovf), 0);
    chk("async_rst.acc2", longint'(dut.acc[2]), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst.in_ready", longint'(in_ready), 1);
    apply('{1, 2, 4, 1, 1, 1, 1, 2, 4, 0}, 106);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_acc_bank.md
MAC_ACC_BANK -- requirements
Module: mac_acc_bank

Interface
REQ-001 Parameter DATA_W, default 16: width of the signed input product.
REQ-002 Parameter ACC_W, default 22: width of each signed accumulator; ACC_W SHALL be >= DATA_W.
REQ-003 Parameter NCH, default 4: number of independent accumulator channels; NCH SHALL be >= 2.
REQ-004 Parameter CH_W, default $clog2(NCH): width of the channel index.
REQ-005 clk  input  1  clock; all state SHALL change on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 clr  input  1  synchronous clear of all channels and of the output register.
REQ-008 in_valid  input  1  input beat present.
REQ-009 in_ready  output  1  block accepts an input beat this cycle.
REQ-010 in_ch  input  CH_W  target channel of the beat.
REQ-011 in_data  input  DATA_W  signed product to accumulate.
REQ-012 in_last  input  1  final beat of a dot product; closes the channel's sum.
REQ-013 out_valid  output  1  result held in the output register.
REQ-014 out_ready  input  1  consumer takes the result this cycle.
REQ-015 out_ch  output  CH_W  channel of the held result.
REQ-016 out_data  output  ACC_W  signed final sum.
REQ-017 out_ovf  output  1  the held sum overflowed at least once.

Function
REQ-018 A beat SHALL be accepted when in_valid && in_ready; in_ready SHALL equal !out_valid || out_ready.
REQ-019 On an accepted non-last beat: acc[in_ch] <= acc[in_ch] + sign-extend(in_data) to ACC_W; the other channels are unchanged.
REQ-020 On an accepted last beat: out_data <= acc[in_ch] + sign-extend(in_data), out_ch <= in_ch, out_valid <= 1, acc[in_ch] <= 0, ovf[in_ch] <= 0.
REQ-021 Latency: out_valid SHALL rise on the clock edge that accepts the last beat, so it is visible in the following cycle.
REQ-022 out_valid SHALL fall on out_valid && out_ready, unless a new last beat is accepted in the same cycle; in that case the output register reloads and out_valid stays 1.
REQ-023 out_data, out_ch and out_ovf SHALL remain stable while out_valid && !out_ready.
REQ-024 A beat with in_ch >= NCH SHALL be accepted and discarded with no state change, including when in_last is set.
REQ-025 A per-channel sticky ovf[ch] flag SHALL capture signed overflow of any add into that channel; out_ovf SHALL equal ovf[ch] OR'd with the overflow of the final add.
REQ-026 clr SHALL have priority over every other event: all acc and ovf SHALL become 0 and out_valid SHALL become 0. A beat presented in the same cycle is dropped; in_ready is unaffected.
REQ-027 Successive beats to different channels SHALL interleave freely, at most one beat per cycle.

Reset
REQ-028 On reset assertion, independent of clk: all acc = 0, all ovf = 0, out_valid = 0, out_data = 0, out_ch = 0, out_ovf = 0.
REQ-029 Reset asserted mid-sum SHALL discard all partial sums and any pending output; in_ready SHALL read 1 as soon as reset is released.

Configuration
REQ-030 Macro MAC_ACC_SAT_EN, when defined: an overflowing add SHALL clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1), and ovf SHALL be set.
REQ-031 Macro MAC_ACC_SAT_EN, when undefined: adds SHALL wrap modulo 2^ACC_W, and ovf / out_ovf SHALL still report signed overflow.

Verification
REQ-032 Channel 0 receives beats 100, -30, 5(last) -> a single out_valid pulse with out_ch=0, out_data=75, out_ovf=0.
REQ-033 Interleaved beats ch1:10, ch2:20, ch1:7(last), ch2:-25(last) with out_ready=1 -> outputs (1,17) then (2,-5); both channels then read 0 internally.
REQ-034 out_ready=0 with out_valid=1 and another last beat offered -> in_ready=0, output held stable; out_ready=1 -> new result loads in the same cycle and out_valid stays high.
REQ-035 Defaults with MAC_ACC_SAT_EN defined: 65 beats of 32767 into ch3, last on the 65th -> out_data=2097151, out_ovf=1. Without the macro -> out_data=2129855-4194304=-2064449, out_ovf=1.
REQ-036 clr pulsed together with an accepted last beat on ch0 holding 50 -> no output, acc[0]=0; reset asserted mid-sum on ch2 -> all outputs 0 asynchronously, and the next last beat of 4 yields out_data=4.
REQ-037 Beat with in_ch=5 when NCH=4 -> accepted, no output produced, all channel sums unchanged.
